// File: rtl/cnn_mul_pkg.sv
// Shared constants and helpers for the cnn_mul pipelined multiplier:
// product width, legal stage-count bounds and saturation limits.
package cnn_mul_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 4;

    // Wide enough to hold any product (max 65 bits) plus a sign bit for compares.
    localparam int SAT_W = 66;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_hi(input logic is_signed, input int w);
        logic signed [SAT_W-1:0] one;
        one = SAT_W'(1);
        return is_signed ? (one <<< (w - 1)) - one : (one <<< w) - one;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_lo(input logic is_signed, input int w);
        logic signed [SAT_W-1:0] one;
        one = SAT_W'(1);
        return is_signed ? -(one <<< (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/cnn_mul_stage.sv
// One pipeline register slice: data plus valid bit, loaded on advance,
// cleared by synchronous reset.
module cnn_mul_stage #(
    parameter int W = 8
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         i_advance,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_advance) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/cnn_mul_pipe.sv
// Pipelined multiplier with valid/ready flow control and clock enable.
// Define CNN_MUL_SAT_EN to clamp the result to the dout range instead of wrapping.
module cnn_mul_pipe
    import cnn_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 5,
    parameter int din1_WIDTH  = 7,
    parameter int dout_WIDTH  = 11,
    parameter int din0_SIGNED = 0,
    parameter int din1_SIGNED = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int P = prod_width(din0_WIDTH, din1_WIDTH);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
        $error("cnn_mul_pipe: NUM_STAGE out of range");
    end

    logic w_advance;
    logic w_out_valid;

    // A full output register that nobody takes stalls the whole pipe.
    assign w_advance = ce & (~w_out_valid | out_ready);
    assign in_ready  = w_advance;
    assign out_valid = w_out_valid;

    logic [P-1:0] w_a_ext;
    logic [P-1:0] w_b_ext;
    logic [P-1:0] w_prod;

    if (din0_SIGNED != 0) begin : g_a_sx
        assign w_a_ext = {{(P-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
    end else begin : g_a_zx
        assign w_a_ext = {{(P-din0_WIDTH){1'b0}}, din0};
    end

    if (din1_SIGNED != 0) begin : g_b_sx
        assign w_b_ext = {{(P-din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
    end else begin : g_b_zx
        assign w_b_ext = {{(P-din1_WIDTH){1'b0}}, din1};
    end

    // Low P bits of the extended product are exact for every signedness mix.
    assign w_prod = w_a_ext * w_b_ext;

    logic [P-1:0] w_d [0:NUM_STAGE-1];
    logic         w_v [0:NUM_STAGE-1];

    assign w_d[0] = w_prod;
    assign w_v[0] = in_valid;

    for (genvar k = 1; k < NUM_STAGE; k++) begin : g_stage
        cnn_mul_stage #(.W(P)) u_stage (
            .ap_clk    (ap_clk),
            .ap_rst    (ap_rst),
            .i_advance (w_advance),
            .i_valid   (w_v[k-1]),
            .i_data    (w_d[k-1]),
            .o_valid   (w_v[k]),
            .o_data    (w_d[k])
        );
    end

    logic [dout_WIDTH-1:0] w_last_d;

`ifdef CNN_MUL_SAT_EN
    localparam logic ANY_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
    localparam logic signed [SAT_W-1:0] SAT_HI = sat_hi(ANY_SIGNED, dout_WIDTH);
    localparam logic signed [SAT_W-1:0] SAT_LO = sat_lo(ANY_SIGNED, dout_WIDTH);

    logic signed [SAT_W-1:0] w_full;
    assign w_full = $signed({{(SAT_W-P){w_d[NUM_STAGE-1][P-1]}}, w_d[NUM_STAGE-1]});

    always_comb begin
        w_last_d = w_full[dout_WIDTH-1:0];
        if (w_full > SAT_HI) begin
            w_last_d = SAT_HI[dout_WIDTH-1:0];
        end else if (w_full < SAT_LO) begin
            w_last_d = SAT_LO[dout_WIDTH-1:0];
        end
    end
`else
    assign w_last_d = w_d[NUM_STAGE-1][dout_WIDTH-1:0];

    logic w_unused_hi;
    assign w_unused_hi = ^w_d[NUM_STAGE-1][P-1:dout_WIDTH];
`endif

    // Final stage holds only the dout-wide result.
    cnn_mul_stage #(.W(dout_WIDTH)) u_last (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .i_advance (w_advance),
        .i_valid   (w_v[NUM_STAGE-1]),
        .i_data    (w_last_d),
        .o_valid   (w_out_valid),
        .o_data    (dout)
    );

    logic w_unused_id;
    assign w_unused_id = ^ID;

endmodule

// File: tb/tb_cnn_mul_pipe.sv
// Scoreboard bench for cnn_mul_pipe: an unsigned default instance and a
// signed-A / 12-bit instance share the same stimulus and flow control.
module tb_cnn_mul_pipe;

    localparam int NST = 2;

    logic        ap_clk;
    logic        ap_rst;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_s;
    logic [4:0]  din0;
    logic [6:0]  din1;
    logic        out_valid;
    logic        out_valid_s;
    logic        out_ready;
    logic [10:0] dout;
    logic [11:0] dout_s;

    int tests = 0;
    int fails = 0;

    logic [11:0] exp_q[$];
    logic [11:0] exps_q[$];
    int          lat_q[$];
    int          adv_cnt = 0;
    logic        prev_hold = 1'b0;

    cnn_mul_pipe u_dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    cnn_mul_pipe #(.ID(2), .din0_SIGNED(1), .dout_WIDTH(12)) u_dut_s (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .dout      (dout_s)
    );

    // Clock / reset
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer product of the operands as the spec reads them.
    function automatic logic [63:0] model(input logic [31:0] a_raw, input logic [31:0] b_raw,
                                          input bit a_s, input bit b_s,
                                          input int wa, input int wb, input int wo);
        longint a, b, p, one, hi, lo;
        one = 1;
        a = longint'(a_raw);
        b = longint'(b_raw);
        if (a_s && a >= (one << (wa - 1))) a = a - (one << wa);
        if (b_s && b >= (one << (wb - 1))) b = b - (one << wb);
        p = a * b;
`ifdef CNN_MUL_SAT_EN
        if (a_s || b_s) begin
            hi = (one << (wo - 1)) - 1;
            lo = -(one << (wo - 1));
        end else begin
            hi = (one << wo) - 1;
            lo = 0;
        end
        if (p > hi) p = hi;
        else if (p < lo) p = lo;
`else
        hi = 0;
        lo = 0;
`endif
        return 64'(p & ((one << wo) - 1));
    endfunction

    // Monitor / scoreboard: samples 1 time unit before each rising edge.
    always @(negedge ap_clk) begin
        #4;
        if (ap_rst) begin
            exp_q.delete();
            exps_q.delete();
            lat_q.delete();
            prev_hold = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, ce && (!out_valid || out_ready));
            chk("out_valid_s", out_valid_s, out_valid);
            if (prev_hold) chk("hold_valid", out_valid, 1);
            if (out_valid) begin
                if (!prev_hold) begin
                    chk("result_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("latency", adv_cnt - lat_q[0], NST);
                end
                if (exp_q.size() != 0) begin
                    chk("dout", dout, exp_q[0]);
                    chk("dout_s", dout_s, exps_q[0]);
                    if (ce && out_ready) begin
                        void'(exp_q.pop_front());
                        void'(exps_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
            prev_hold = out_valid && !(ce && out_ready);
            if (in_valid && in_ready) begin
                exp_q.push_back(12'(model(32'(din0), 32'(din1), 0, 0, 5, 7, 11)));
                exps_q.push_back(12'(model(32'(din0), 32'(din1), 1, 0, 5, 7, 12)));
                lat_q.push_back(adv_cnt);
            end
            if (ce && (!out_valid || out_ready)) adv_cnt++;
        end
    end

    // Driver: present one pair from a falling edge until it is accepted.
    task automatic send(input int a, input int b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        din0 = 5'(a);
        din1 = 7'(b);
        for (int t = 0; t < 200 && !acc; t++) begin
            #4;
            acc = in_ready;
            @(negedge ap_clk);
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ap_clk);
    endtask

    initial begin
        bit done;
        ap_rst = 1'b1;
        ce = 1'b1;
        in_valid = 1'b0;
        din0 = '0;
        din1 = '0;
        out_ready = 1'b1;
        idle(3);
        ap_rst = 1'b0;
        #4;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_dout", dout, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge ap_clk);

        // Directed: max unsigned operands, exact latency.
        send(31, 127);
        chk("lat_not_early", out_valid, 0);
        @(negedge ap_clk);
        chk("lat_valid", out_valid, 1);
`ifdef CNN_MUL_SAT_EN
        chk("max_prod", dout, 2047);
`else
        chk("max_prod", dout, 1889);
`endif
        idle(3);

        // Directed: most negative signed A.
        send(16, 127);
        @(negedge ap_clk);
        chk("signed_min_s", dout_s, 12'h810);
        chk("signed_min_u", dout, 2032);
        idle(3);

        // Back-to-back stream with a 3-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) send($urandom_range(0, 31), $urandom_range(0, 127));
            end
            begin
                idle(5);
                out_ready = 1'b0;
                repeat (3) begin
                    #4;
                    chk("stall_in_ready", in_ready, 0);
                    @(negedge ap_clk);
                end
                out_ready = 1'b1;
            end
        join
        idle(6);

        // ce low while a result is offered: nothing retires until ce returns.
        out_ready = 1'b0;
        send(21, 99);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge ap_clk);
        chk("ce_wait_valid", out_valid, 1);
        ce = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            #4;
            chk("ce_hold_valid", out_valid, 1);
            @(negedge ap_clk);
        end
        ce = 1'b1;
        @(negedge ap_clk);
        chk("ce_retired", out_valid, 0);
        idle(2);

        // Reset with two pairs in flight.
        send(3, 5);
        send(7, 9);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #4;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_dout", dout, 0);
        @(negedge ap_clk);
        idle(6);

        // Randomized traffic with random ce and back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send($urandom_range(0, 31), $urandom_range(0, 127));
                    idle($urandom_range(0, 2));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ce = ($urandom_range(0, 9) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge ap_clk);
                end
            end
        join
        ce = 1'b1;
        out_ready = 1'b1;

        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge ap_clk);
        chk("drain", exp_q.size(), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
